mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4: consecutive data-won arbitrations before fetch is forced to win.
REQ-002 Parameter TIMEOUT, default 64: cycles to wait for mem_ready before abort; used only under ARB_TIMEOUT_EN.
REQ-003 Port clk  in  1  clock.
REQ-004 Port reset  in  1  synchronous, active-low reset.
REQ-005 Ports if_req in 1 fetch request; if_addr in 32 fetch address; if_gnt out 1 fetch accepted; if_rvalid out 1 fetch data valid; if_rdata out 32 fetch data.
REQ-006 Ports d_req in 1 data request; d_we in 1 store; d_addr in 32 address; d_wdata in 32 store data; d_width in 3 funct3 width code; d_gnt out 1 accepted; d_rvalid out 1 completion; d_rdata out 32 load data, extended; d_misaligned out 1 alignment fault.
REQ-007 Ports mem_req out 1 transaction active; mem_we out 1; mem_addr out 32 word-aligned; mem_be out 4 byte enables; mem_wdata out 32; mem_ready in 1 completion; mem_rdata in 32 read word.
REQ-008 Port bus_err  out  1  timeout abort pulse; tied 0 without ARB_TIMEOUT_EN.

Function
REQ-009 FSM states SHALL be IDLE, BUSY_I, BUSY_D; one memory transaction outstanding at most.
REQ-010 In IDLE, d_req alone SHALL go to BUSY_D; if_req alone SHALL go to BUSY_I; neither SHALL stay IDLE.
REQ-011 Both requesting in IDLE: data SHALL win unless starve count equals MAX_WAIT, then fetch SHALL win.
REQ-012 Starve count SHALL increment when data wins while if_req is high, clear when fetch is granted, and saturate at MAX_WAIT.
REQ-013 Winning port's gnt SHALL pulse high one cycle, in the IDLE cycle of the decision; requesters hold req and operands until gnt.
REQ-014 On grant, mem_addr, mem_we, mem_be and mem_wdata SHALL be registered and held stable, with mem_req high, until mem_ready.
REQ-015 mem_addr SHALL equal {addr[31:2],2'b00}; fetch mem_be SHALL be 4'b1111 and mem_we 0.
REQ-016 Store width 000: be = 4'b0001<<addr[1:0], wdata byte replicated x4; 001: be = 4'b0011<<addr[1:0], halfword replicated x2; 010: be = 4'b1111.
REQ-017 Data request with d_width 001/101 and addr[0]=1, or 010 and addr[1:0]!=0, SHALL pulse d_misaligned instead of d_gnt, issue no transaction, stay IDLE.
REQ-018 d_width 011, 110, 111 SHALL be treated as misaligned.
REQ-019 mem_ready in BUSY_x SHALL pulse the owner's rvalid the same cycle (combinational data path) and return to IDLE next cycle.
REQ-020 Load data SHALL be lane-selected by registered addr[1:0]: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU, 101 LHU zero-extend.
REQ-021 Store completion SHALL pulse d_rvalid with d_rdata = 0.
REQ-022 mem_ready in IDLE SHALL be ignored.
REQ-023 Requests arriving while BUSY SHALL be held off (no gnt) and arbitrated in the next IDLE cycle.

Reset
REQ-024 reset=0 at a clk edge SHALL force IDLE, starve count 0, timeout counter 0, and all outputs 0.
REQ-025 Reset mid-transaction SHALL abandon it silently; a late mem_ready after reset SHALL produce no rvalid.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: counter in BUSY_x counts cycles; after TIMEOUT cycles without mem_ready, SHALL pulse bus_err one cycle, drop mem_req, return to IDLE, no rvalid.
REQ-027 Macro ARB_TIMEOUT_EN undefined: no counter; BUSY_x waits indefinitely; bus_err constant 0.

Verification
REQ-028 Load d_addr=0x102, d_width=001, mem_rdata=0x8001_0000 -> mem_addr=0x100, mem_be=4'b1100, d_rdata=0xFFFF_8001.
REQ-029 Store d_addr=0x203, d_width=000, d_wdata=0x0000_00A5 -> mem_be=4'b1000, mem_wdata=0xA5A5_A5A5, d_rvalid with d_rdata=0.
REQ-030 if_req and d_req held high continuously, mem_ready after 1 cycle, MAX_WAIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-031 d_addr=0x6, d_width=010 -> d_misaligned pulse, mem_req stays 0, no d_gnt.
REQ-032 reset low during BUSY_D, mem_ready one cycle after reset release -> state IDLE, no d_rvalid.
REQ-033 ARB_TIMEOUT_EN, TIMEOUT=64, mem_ready never asserted -> bus_err pulse 64 cycles after grant, mem_req low, next request granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester (if_*) and a
// load/store requester (d_*). At most one memory transaction is outstanding.
// Data normally wins arbitration. After MAX_WAIT consecutive data wins
// against a waiting fetch, the fetch is forced through.
//
// Ports:
//   clk, reset         clock; synchronous active-low reset
//   if_req/if_addr     fetch request and address
//   if_gnt             fetch accepted (one-cycle pulse in the decision cycle)
//   if_rvalid/if_rdata fetch completion and read word
//   d_req/d_we/d_addr/d_wdata/d_width
//                      data request, store flag, address, store data, funct3 width
//   d_gnt              data accepted (one-cycle pulse)
//   d_misaligned       alignment fault pulse, issued instead of d_gnt
//   d_rvalid/d_rdata   data completion and lane-selected, extended load data
//   mem_*              registered memory-side request; mem_ready/mem_rdata complete it
//   bus_err            timeout abort pulse
//
// Optional feature: define ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT cycles without mem_ready. Without it, bus_err is tied low and a
// transaction waits indefinitely.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_width,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    localparam int SW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] MAX_WAIT_C = SW'(MAX_WAIT);

    // Widths 000/100 are always aligned; halfwords need addr[0]=0; words need
    // addr[1:0]=0; the remaining codes are not legal accesses at all.
    function automatic logic misaligned_f(input logic [2:0] width, input logic [1:0] off);
        logic r;
        case (width)
            3'b000, 3'b100: r = 1'b0;
            3'b001, 3'b101: r = off[0];
            3'b010:         r = (off != 2'b00);
            default:        r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] be_f(input logic [2:0] width, input logic [1:0] off);
        logic [3:0] r;
        case (width[1:0])
            2'b00:   r = 4'b0001 << off;
            2'b01:   r = 4'b0011 << off;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    // Replicating the narrow store value puts it on every lane; mem_be picks the lane.
    function automatic logic [31:0] wdata_f(input logic [2:0] width, input logic [31:0] wdata);
        logic [31:0] r;
        case (width[1:0])
            2'b00:   r = {4{wdata[7:0]}};
            2'b01:   r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_f(input logic [2:0] width, input logic [1:0] off,
                                           input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {off, 3'b000};
        case (width)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b010:  r = rdata;
            3'b100:  r = {24'h000000, sh[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [SW-1:0] starve_r;
    logic [SW-1:0] starve_nxt_s;
    logic          grant_i_s;
    logic          grant_d_s;
    logic          misal_s;
    logic          done_s;
    logic          abort_s;
    logic          tmo_hit_s;
    logic          mem_req_r;
    logic          mem_we_r;
    logic [31:0]   mem_addr_r;
    logic [3:0]    mem_be_r;
    logic [31:0]   mem_wdata_r;
    logic [2:0]    width_r;
    logic [1:0]    off_r;
    logic          unused_s;

    assign unused_s = ^{if_addr[1:0], 32'(TIMEOUT)};

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_r;

    assign tmo_hit_s = (state_r != IDLE) && (tmo_r == TMO_LAST);

    // Busy-cycle counter; restarts on every transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_r <= '0;
        end else if ((state_r != IDLE) && !done_s && !abort_s) begin
            tmo_r <= tmo_r + TW'(1);
        end else begin
            tmo_r <= '0;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Arbitration, starvation tracking and completion decode.
    always_comb begin
        state_nxt_s  = state_r;
        starve_nxt_s = starve_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        misal_s      = 1'b0;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req && !(if_req && (starve_r == MAX_WAIT_C))) begin
                    // A misaligned request still counts as a data win so a
                    // stuck faulting requester cannot starve fetch forever.
                    if (if_req && (starve_r < MAX_WAIT_C)) begin
                        starve_nxt_s = starve_r + SW'(1);
                    end else begin
                        starve_nxt_s = starve_r;
                    end
                    if (misaligned_f(d_width, d_addr[1:0])) begin
                        misal_s = 1'b1;
                    end else begin
                        grant_d_s   = 1'b1;
                        state_nxt_s = BUSY_D;
                    end
                end else if (if_req) begin
                    grant_i_s    = 1'b1;
                    starve_nxt_s = '0;
                    state_nxt_s  = BUSY_I;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else if (tmo_hit_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, starve count and the held memory-side request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            starve_r    <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            width_r     <= 3'b000;
            off_r       <= 2'b00;
        end else begin
            state_r  <= state_nxt_s;
            starve_r <= starve_nxt_s;
            if (grant_i_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= 1'b0;
                mem_addr_r  <= {if_addr[31:2], 2'b00};
                mem_be_r    <= 4'b1111;
                mem_wdata_r <= 32'h0000_0000;
                width_r     <= 3'b010;
                off_r       <= 2'b00;
            end else if (grant_d_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= d_we;
                mem_addr_r  <= {d_addr[31:2], 2'b00};
                mem_be_r    <= be_f(d_width, d_addr[1:0]);
                mem_wdata_r <= d_we ? wdata_f(d_width, d_wdata) : 32'h0000_0000;
                width_r     <= d_width;
                off_r       <= d_addr[1:0];
            end else if (done_s || abort_s) begin
                mem_req_r   <= 1'b0;
                mem_we_r    <= 1'b0;
                mem_addr_r  <= 32'h0000_0000;
                mem_be_r    <= 4'b0000;
                mem_wdata_r <= 32'h0000_0000;
                width_r     <= 3'b000;
                off_r       <= 2'b00;
            end else begin
                mem_req_r <= mem_req_r;
            end
        end
    end

    // Decision and completion pulses are combinational; gating with reset
    // keeps every output low while reset is asserted.
    assign if_gnt       = reset & grant_i_s;
    assign d_gnt        = reset & grant_d_s;
    assign d_misaligned = reset & misal_s;
    assign if_rvalid    = reset & done_s & (state_r == BUSY_I);
    assign d_rvalid     = reset & done_s & (state_r == BUSY_D);
    assign if_rdata     = if_rvalid ? mem_rdata : 32'h0000_0000;
    assign d_rdata      = (d_rvalid && !mem_we_r) ? load_f(width_r, off_r, mem_rdata)
                                                  : 32'h0000_0000;
    assign bus_err      = reset & abort_s;
    assign mem_req      = mem_req_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_be       = mem_be_r;
    assign mem_wdata    = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a directed vector table of single
// data transactions, hand-written multi-cycle sequences (grant order,
// reset mid-transaction, optional timeout) and randomized traffic compared
// against a behavioural reference model.
module tb_mem_port_arbiter;
    localparam int MAX_WAIT = 4;
    localparam int TIMEOUT  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [2:0]  d_width;
    logic        d_gnt, d_rvalid, d_misaligned;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_width(d_width), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_misaligned(d_misaligned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model helpers (from the access rules) -----
    function automatic bit m_misal(input int w, input int off);
        if (w == 0 || w == 4) return 1'b0;
        if (w == 1 || w == 5) return (off % 2) != 0;
        if (w == 2) return off != 0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_be(input int w, input int off);
        int nbytes;
        int mask;
        nbytes = (w % 4 == 0) ? 1 : ((w % 4 == 1) ? 2 : 4);
        mask = ((1 << nbytes) - 1) << off;
        return 4'(mask);
    endfunction

    function automatic logic [31:0] m_wdata(input int w, input logic [31:0] wd);
        if (w % 4 == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (w % 4 == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input int w, input int off, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * off);
        if (w == 0 || w == 4) begin
            v = v & 32'hFF;
            if (w == 0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (w == 1 || w == 5) begin
            v = v & 32'hFFFF;
            if (w == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- directed vector table --------------------------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  width;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] e_maddr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl [16];
    logic exp_fetch [10];

    bit          f_act, d_act, dwe;
    logic [31:0] f_addr, da, dwd;
    logic [2:0]  dw;
    bit          m_busy, p_fetch, p_we;
    logic [31:0] p_addr, p_wdata;
    logic [2:0]  p_width;
    int          m_starve, m_wait, waited;
    bit          e_ig, e_dg, e_mis, e_irv, e_drv;
    logic [31:0] e_drd;

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_width = 3'b000;
        mem_ready = 1'b0; mem_rdata = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 32'h102, 3'b001, 32'h0, 32'h8001_0000, 1'b0, 32'h100, 4'b1100, 32'h0, 32'hFFFF_8001};
        tbl[1]  = '{1'b1, 32'h203, 3'b000, 32'hA5, 32'h0, 1'b0, 32'h200, 4'b1000, 32'hA5A5_A5A5, 32'h0};
        tbl[2]  = '{1'b0, 32'h6, 3'b010, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        tbl[3]  = '{1'b0, 32'h1, 3'b000, 32'h0, 32'h0000_8000, 1'b0, 32'h0, 4'b0010, 32'h0, 32'hFFFF_FF80};
        tbl[4]  = '{1'b0, 32'h3, 3'b100, 32'h0, 32'hF234_5678, 1'b0, 32'h0, 4'b1000, 32'h0, 32'h0000_00F2};
        tbl[5]  = '{1'b0, 32'h2, 3'b101, 32'h0, 32'h9ABC_1234, 1'b0, 32'h0, 4'b1100, 32'h0, 32'h0000_9ABC};
        tbl[6]  = '{1'b0, 32'h10C, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h10C, 4'b1111, 32'h0, 32'hDEAD_BEEF};
        tbl[7]  = '{1'b1, 32'h2E, 3'b001, 32'h1234_BEEF, 32'hFFFF_FFFF, 1'b0, 32'h2C, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        tbl[8]  = '{1'b1, 32'h40, 3'b010, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h40, 4'b1111, 32'hCAFE_F00D, 32'h0};
        tbl[9]  = '{1'b0, 32'h5, 3'b001, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        tbl[10] = '{1'b0, 32'h0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        tbl[11] = '{1'b0, 32'h0, 3'b110, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        tbl[12] = '{1'b1, 32'h4, 3'b111, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        tbl[13] = '{1'b0, 32'h0, 3'b001, 32'h0, 32'h1234_7FFF, 1'b0, 32'h0, 4'b0011, 32'h0, 32'h0000_7FFF};
        tbl[14] = '{1'b0, 32'h1, 3'b101, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        tbl[15] = '{1'b0, 32'h2, 3'b000, 32'h0, 32'h00AB_0000, 1'b0, 32'h0, 4'b0100, 32'h0, 32'hFFFF_FFAB};
        exp_fetch = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // ---- reset: requests present, every output must stay low ----
        idle_inputs();
        reset = 1'b0;
        if_req = 1'b1; d_req = 1'b1; d_addr = 32'h10; d_width = 3'b010;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", 32'({mem_req, mem_we, mem_be, if_gnt, d_gnt, d_misaligned,
                               if_rvalid, d_rvalid, bus_err}), 32'h0);
        chk("reset_addr", mem_addr, 32'h0);
        chk("reset_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0; reset = 1'b1;

        // ---- both requesting continuously: D,D,D,D,I,D,D,D,D,I ----
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h1004; d_req = 1'b1; d_we = 1'b0;
            d_addr = 32'h10; d_width = 3'b010; mem_ready = 1'b0;
            #1;
            chk("order_if_gnt", 32'(if_gnt), 32'(exp_fetch[k]));
            chk("order_d_gnt", 32'(d_gnt), 32'(!exp_fetch[k]));
            @(negedge clk);
            mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
            #1;
            chk("busy_holdoff", 32'({if_gnt, d_gnt}), 32'h0);
            chk("order_rvalid", 32'({if_rvalid, d_rvalid}), exp_fetch[k] ? 32'd2 : 32'd1);
            chk("order_addr_seen", mem_addr, exp_fetch[k] ? 32'h1004 : 32'h10);
        end
        @(negedge clk);
        idle_inputs();

        // ---- directed single data transactions ----
        foreach (tbl[i]) begin
            @(negedge clk);
            d_req = 1'b1; d_we = tbl[i].we; d_addr = tbl[i].addr;
            d_width = tbl[i].width; d_wdata = tbl[i].wdata; mem_ready = 1'b0;
            #1;
            chk("tbl_gnt", 32'(d_gnt), 32'(!tbl[i].mis));
            chk("tbl_misaligned", 32'(d_misaligned), 32'(tbl[i].mis));
            @(negedge clk);
            d_req = 1'b0;
            #1;
            if (tbl[i].mis) begin
                chk("tbl_mis_no_req", 32'(mem_req), 32'h0);
            end else begin
                chk("tbl_mem_req", 32'(mem_req), 32'h1);
                chk("tbl_mem_we", 32'(mem_we), 32'(tbl[i].we));
                chk("tbl_mem_addr", mem_addr, tbl[i].e_maddr);
                chk("tbl_mem_be", 32'(mem_be), 32'(tbl[i].e_be));
                chk("tbl_mem_wdata", mem_wdata, tbl[i].e_wdata);
                @(negedge clk);
                mem_ready = 1'b1; mem_rdata = tbl[i].rdata;
                #1;
                chk("tbl_rvalid", 32'(d_rvalid), 32'h1);
                chk("tbl_rdata", d_rdata, tbl[i].e_rdata);
                @(negedge clk);
                mem_ready = 1'b0;
                #1;
                chk("tbl_done_idle", 32'(mem_req), 32'h0);
            end
        end

        // ---- mem_ready while idle is ignored ----
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        #1;
        chk("idle_ready_rvalid", 32'({if_rvalid, d_rvalid}), 32'h0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("idle_ready_no_req", 32'(mem_req), 32'h0);

        // ---- reset during BUSY_D, late mem_ready afterwards ----
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_width = 3'b010;
        #1;
        chk("rst_mid_gnt", 32'(d_gnt), 32'h1);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(mem_req), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_req_drop", 32'(mem_req), 32'h0);
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        chk("rst_mid_late_ready", 32'({if_rvalid, d_rvalid}), 32'h0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("rst_mid_idle", 32'(mem_req), 32'h0);

`ifdef ARB_TIMEOUT_EN
        // ---- timeout abort without mem_ready ----
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_width = 3'b010;
        #1;
        chk("tmo_gnt", 32'(d_gnt), 32'h1);
        waited = 0;
        while (waited < 200 && bus_err !== 1'b1) begin
            @(negedge clk);
            d_req = 1'b0;
            #1;
            waited++;
        end
        chk("tmo_cycles", 32'(waited), 32'(TIMEOUT));
        chk("tmo_no_rvalid", 32'(d_rvalid), 32'h0);
        @(negedge clk);
        #1;
        chk("tmo_req_drop", 32'({mem_req, bus_err}), 32'h0);
        @(negedge clk);
        d_req = 1'b1;
        #1;
        chk("tmo_next_gnt", 32'(d_gnt), 32'h1);
        @(negedge clk);
        d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        #1;
        chk("tmo_next_done", 32'(d_rvalid), 32'h1);
        @(negedge clk);
        mem_ready = 1'b0;
`endif

        // ---- randomized traffic against the reference model ----
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_busy = 1'b0; m_starve = 0; m_wait = 0;
        f_act = 1'b0; d_act = 1'b0;
        f_addr = 32'h0; da = 32'h0; dwd = 32'h0; dw = 3'b000; dwe = 1'b0;
        p_fetch = 1'b0; p_we = 1'b0; p_addr = 32'h0; p_wdata = 32'h0; p_width = 3'b000;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if_req = f_act; if_addr = f_addr;
            d_req = d_act; d_we = dwe; d_addr = da; d_width = dw; d_wdata = dwd;
            mem_rdata = $urandom;
            mem_ready = (m_busy && m_wait >= 40) ? 1'b1 : ($urandom_range(0, 2) == 0);
            #1;
            e_ig = 1'b0; e_dg = 1'b0; e_mis = 1'b0; e_irv = 1'b0; e_drv = 1'b0; e_drd = 32'h0;
            if (!m_busy) begin
                chk("rnd_idle_req", 32'(mem_req), 32'h0);
                if (d_req && !(if_req && m_starve == MAX_WAIT)) begin
                    if (if_req && m_starve < MAX_WAIT) m_starve++;
                    if (m_misal(int'(d_width), int'(d_addr[1:0]))) begin
                        e_mis = 1'b1;
                    end else begin
                        e_dg = 1'b1; m_busy = 1'b1; m_wait = 0; p_fetch = 1'b0;
                        p_addr = d_addr; p_we = d_we; p_width = d_width; p_wdata = d_wdata;
                    end
                end else if (if_req) begin
                    e_ig = 1'b1; m_starve = 0; m_busy = 1'b1; m_wait = 0; p_fetch = 1'b1;
                    p_addr = if_addr; p_we = 1'b0; p_width = 3'b010; p_wdata = 32'h0;
                end
            end else begin
                chk("rnd_busy_req", 32'(mem_req), 32'h1);
                chk("rnd_addr", mem_addr, p_addr & 32'hFFFF_FFFC);
                chk("rnd_we", 32'(mem_we), 32'(p_we));
                chk("rnd_be", 32'(mem_be),
                    p_fetch ? 32'hF : 32'(m_be(int'(p_width), int'(p_addr[1:0]))));
                chk("rnd_wdata", mem_wdata,
                    (p_fetch || !p_we) ? 32'h0 : m_wdata(int'(p_width), p_wdata));
                m_wait++;
                if (mem_ready) begin
                    if (p_fetch) begin
                        e_irv = 1'b1;
                    end else begin
                        e_drv = 1'b1;
                        e_drd = p_we ? 32'h0 : m_load(int'(p_width), int'(p_addr[1:0]), mem_rdata);
                    end
                    m_busy = 1'b0;
                end
            end
            chk("rnd_if_gnt", 32'(if_gnt), 32'(e_ig));
            chk("rnd_d_gnt", 32'(d_gnt), 32'(e_dg));
            chk("rnd_misaligned", 32'(d_misaligned), 32'(e_mis));
            chk("rnd_if_rvalid", 32'(if_rvalid), 32'(e_irv));
            chk("rnd_d_rvalid", 32'(d_rvalid), 32'(e_drv));
            chk("rnd_bus_err", 32'(bus_err), 32'h0);
            if (e_irv) chk("rnd_if_rdata", if_rdata, mem_rdata);
            if (e_drv) chk("rnd_d_rdata", d_rdata, e_drd);
            // requesters hold until accepted, then maybe issue a fresh request
            if (f_act && e_ig) f_act = 1'b0;
            if (d_act && (e_dg || e_mis)) d_act = 1'b0;
            if (!f_act && $urandom_range(0, 2) == 0) begin
                f_act = 1'b1; f_addr = $urandom;
            end
            if (!d_act && $urandom_range(0, 1) == 0) begin
                d_act = 1'b1; dwe = 1'($urandom_range(0, 1)); da = $urandom; dwd = $urandom;
                dw = dwe ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
